// File: rtl/srl16_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : srl16_fifo
//  Purpose  : First-word-fall-through FIFO built on a 16-entry shift-register
//             storage array (SRL16 style). Writes shift in at entry 0. The
//             oldest word sits at entry COUNT-1, which is also the read
//             address.
//  Ports    : CLK         clock, rising edge
//             CLR_N       asynchronous active-low reset
//             WR_EN       push request
//             WR_DATA     push data [WIDTH-1:0]
//             WR_READY    push will be accepted this cycle
//             RD_EN       pop request (acts only while RD_VALID=1)
//             RD_DATA     oldest entry, combinational from storage
//             RD_VALID    FIFO not empty
//             COUNT       occupancy 0..DEPTH [4:0]
//             FULL/EMPTY/ALMOST_FULL  registered occupancy flags
//             OVFL/UDFL   sticky error flags (only with SRL16_FIFO_ERR_EN)
//  Options  : `define SRL16_FIFO_ERR_EN adds the OVFL/UDFL ports.
//  Revision : 1.0  initial release
// ============================================================================
module srl16_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_READY,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic [4:0]       COUNT,
  output logic             FULL,
  output logic             EMPTY,
`ifdef SRL16_FIFO_ERR_EN
  output logic             OVFL,
  output logic             UDFL,
`endif
  output logic             ALMOST_FULL
);

  localparam logic [4:0] c_DEPTH = 5'(DEPTH);
  localparam logic [4:0] c_AFULL = 5'(AFULL_LVL);

  // Storage is always 16 entries like the primitive; DEPTH only limits
  // occupancy, so the 4-bit address never indexes past the array.
  logic [WIDTH-1:0] data_q [16];

  logic [4:0] count_q, count_d;
  logic       full_q, empty_q, afull_q, valid_q;
  logic       w_push, w_pop;
  logic [3:0] w_addr;

  assign WR_READY = ~full_q | RD_EN;
  assign w_push   = WR_EN & WR_READY;
  assign w_pop    = RD_EN & valid_q;

  // At COUNT=16 the low nibble is 0, and 0-1 wraps to 15, which is correct.
  assign w_addr   = (count_q == 5'd0) ? 4'd0 : (count_q[3:0] - 4'd1);
  assign RD_DATA  = data_q[w_addr];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 5'd1;
    end else if (w_pop && !w_push) begin
      count_d = count_q - 5'd1;
    end
  end

  // Shift storage: no reset, matching SRL primitive behaviour.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      data_q[0] <= WR_DATA;
      for (int i = 1; i < 16; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Flags are decoded from the next count and registered, so they change
  // only on the clock edge together with COUNT.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      count_q <= 5'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == c_DEPTH);
      empty_q <= (count_d == 5'd0);
      afull_q <= (count_d >= c_AFULL);
      valid_q <= (count_d != 5'd0);
    end
  end

  assign COUNT       = count_q;
  assign FULL        = full_q;
  assign EMPTY       = empty_q;
  assign ALMOST_FULL = afull_q;
  assign RD_VALID    = valid_q;

`ifdef SRL16_FIFO_ERR_EN
  logic ovfl_q, udfl_q;

  // Sticky until reset; purely observational, never gates FIFO state.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ovfl_q <= 1'b0;
      udfl_q <= 1'b0;
    end else begin
      if (WR_EN && !WR_READY) ovfl_q <= 1'b1;
      if (RD_EN && !valid_q)  udfl_q <= 1'b1;
    end
  end

  assign OVFL = ovfl_q;
  assign UDFL = udfl_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_srl16_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_srl16_fifo
//  Purpose  : Self-checking bench for srl16_fifo. A queue model tracks the
//             expected contents; every falling edge compares all outputs.
//             Directed sequences add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srl16_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic             CLK   = 1'b0;
  logic             CLR_N = 1'b0;
  logic             WR_EN = 1'b0;
  logic [WIDTH-1:0] WR_DATA = '0;
  logic             WR_READY;
  logic             RD_EN = 1'b0;
  logic [WIDTH-1:0] RD_DATA;
  logic             RD_VALID;
  logic [4:0]       COUNT;
  logic             FULL, EMPTY, ALMOST_FULL;
`ifdef SRL16_FIFO_ERR_EN
  logic             OVFL, UDFL;
  logic             m_ovfl = 1'b0;
  logic             m_udfl = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] m_q [$];

  srl16_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .CLK(CLK), .CLR_N(CLR_N),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
`ifdef SRL16_FIFO_ERR_EN
    .OVFL(OVFL), .UDFL(UDFL),
`endif
    .ALMOST_FULL(ALMOST_FULL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: updated from the pre-edge inputs and queue.
  always @(posedge CLK) begin
    if (CLR_N) begin
      automatic int  n    = m_q.size();
      automatic bit  rdy  = (n != DEPTH) || RD_EN;
      automatic bit  psh  = WR_EN && rdy;
      automatic bit  pp   = RD_EN && (n != 0);
`ifdef SRL16_FIFO_ERR_EN
      if (WR_EN && !rdy) m_ovfl = 1'b1;
      if (RD_EN && n == 0) m_udfl = 1'b1;
`endif
      if (pp)  void'(m_q.pop_front());
      if (psh) m_q.push_back(WR_DATA);
    end
  end

  always @(negedge CLR_N) begin
    m_q.delete();
`ifdef SRL16_FIFO_ERR_EN
    m_ovfl = 1'b0;
    m_udfl = 1'b0;
`endif
  end

  // Compare process.
  always @(negedge CLK) begin
    automatic int n = m_q.size();
    chk("count",    COUNT,       n);
    chk("empty",    EMPTY,       int'(n == 0));
    chk("full",     FULL,        int'(n == DEPTH));
    chk("afull",    ALMOST_FULL, int'(n >= AFULL));
    chk("rd_valid", RD_VALID,    int'(n != 0));
    chk("wr_ready", WR_READY,    int'((n != DEPTH) || RD_EN));
    if (n != 0) chk("rd_data", RD_DATA, m_q[0]);
`ifdef SRL16_FIFO_ERR_EN
    chk("ovfl", OVFL, m_ovfl);
    chk("udfl", UDFL, m_udfl);
`endif
  end

  task automatic step(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    WR_EN   = wr;
    WR_DATA = wd;
    RD_EN   = rd;
    @(posedge CLK);
    #1;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_wr_ready", WR_READY, 1);
    CLR_N = 1'b1;

    // Three pushes then three pops
    step(1, 8'h11, 0);
    chk("lat_valid", RD_VALID, 1);
    chk("lat_data", RD_DATA, 8'h11);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk("p3_count", COUNT, 3);
    chk("p3_data", RD_DATA, 8'h11);
    step(0, 0, 1);
    chk("pop1_data", RD_DATA, 8'h22);
    step(0, 0, 1);
    chk("pop2_data", RD_DATA, 8'h33);
    step(0, 0, 1);
    chk("pop3_empty", EMPTY, 1);
    chk("pop3_count", COUNT, 0);

    // Fill to full, checking the almost-full threshold
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0);
      if (i == 10) chk("afull_at11", ALMOST_FULL, 0);
      if (i == 11) chk("afull_at12", ALMOST_FULL, 1);
    end
    chk("full", FULL, 1);
    chk("full_wr_ready", WR_READY, 0);
    step(1, 8'hAA, 0);
    chk("ovr_count", COUNT, 16);
    chk("ovr_data", RD_DATA, 8'h00);
`ifdef SRL16_FIFO_ERR_EN
    chk("ovfl_set", OVFL, 1);
`endif

    // Push+pop while full
    step(1, 8'h55, 1);
    chk("fpp_count", COUNT, 16);
    chk("fpp_data", RD_DATA, 8'h01);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", RD_DATA, (i < 15) ? i + 1 : 8'h55);
      step(0, 0, 1);
    end
    chk("drain_empty", EMPTY, 1);

    // Push+pop on empty: push only
    step(1, 8'h77, 1);
    chk("epp_count", COUNT, 1);
    chk("epp_data", RD_DATA, 8'h77);
`ifdef SRL16_FIFO_ERR_EN
    chk("udfl_set", UDFL, 1);
`endif
    step(0, 0, 1);

    // Streaming at occupancy 5
    for (int i = 0; i < 5; i++) step(1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 20; i++) begin
      chk("stream_data", RD_DATA, (i < 5) ? 8'hA0 + i : 8'hB0 + i - 5);
      step(1, 8'hB0 + 8'(i), 1);
      chk("stream_count", COUNT, 5);
    end

    // Random traffic, checked by the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Drain, then build occupancy 9 and reset mid-cycle
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() != 0) step(0, 0, 1);
    end
    chk("pre_rst_empty", EMPTY, 1);
    for (int i = 0; i < 9; i++) step(1, 8'hC0 + 8'(i), 0);
    chk("pre_rst_count", COUNT, 9);
    @(negedge CLK);
    #2;
    CLR_N = 1'b0;
    #1;
    chk("arst_count", COUNT, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_valid", RD_VALID, 0);
`ifdef SRL16_FIFO_ERR_EN
    chk("arst_ovfl", OVFL, 0);
    chk("arst_udfl", UDFL, 0);
`endif
    @(posedge CLK);
    #1;
    CLR_N = 1'b1;
    step(1, 8'h3C, 0);
    chk("post_rst_count", COUNT, 1);
    chk("post_rst_data", RD_DATA, 8'h3C);
    step(0, 0, 1);

    @(posedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
